// File: rtl/sensor_monitor_if.sv
// Bundle of sensor inputs, control strobes and status outputs for sensor_monitor.
// The bench drives the master side and the monitor implements the slave side.
interface sensor_monitor_if #(
  parameter int NUM_SENSORS = 4,
  parameter int CNT_WIDTH   = 8
);
  logic [NUM_SENSORS-1:0] sensors;
  logic                   enable;
  logic                   clear;
  logic                   error;
  logic                   error_cond;
  logic [CNT_WIDTH-1:0]   fault_count;
  logic                   busy;

  modport master (
    output sensors, enable, clear,
    input  error, error_cond, fault_count, busy
  );

  modport slave (
    input  sensors, enable, clear,
    output error, error_cond, fault_count, busy
  );
endinterface

// File: rtl/sensor_monitor.sv
// N-channel sensor fault monitor: registered inputs, critical/qualified rule,
// persistence filter, optional sticky latch and saturating fault counter.
module sensor_monitor #(
  parameter int NUM_SENSORS = 4,
  parameter int PERSIST     = 3,
  parameter int CNT_WIDTH   = 8,
  parameter int STICKY      = 1
) (
  input logic        clk,
  input logic        rst,
  sensor_monitor_if.slave mon
);

  localparam int PW = $clog2(PERSIST + 1);
  localparam logic [PW-1:0]        P_ZERO  = {PW{1'b0}};
  localparam logic [PW-1:0]        P_ONE   = PW'(1);
  localparam logic [PW-1:0]        P_LAST  = PW'(PERSIST - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    FAULT   = 2'd2,
    LATCHED = 2'd3
  } state_t;

  logic [NUM_SENSORS-1:0] sensors_r;
  state_t                 state_r, state_s;
  logic [PW-1:0]          p_cnt_r, p_cnt_s;
  logic                   error_r, error_s;
  logic [CNT_WIDTH-1:0]   count_r, count_s;
  logic                   cond_s;
  logic                   fault_entry_s;

  // Channel 0 alone is critical; channel 1 needs any of channels 2..N-1 to qualify it.
  assign cond_s = sensors_r[0] | (sensors_r[1] & (|sensors_r[NUM_SENSORS-1:2]));

  // Next-state, persistence counter, error flag and fault counter decode.
  always_comb begin
    state_s = state_r;
    p_cnt_s = p_cnt_r;
    case (state_r)
      IDLE: begin
        if (mon.enable && cond_s) begin
          if (PERSIST == 1) begin
            state_s = FAULT;
            p_cnt_s = P_ZERO;
          end else begin
            state_s = PENDING;
            p_cnt_s = P_ONE;
          end
        end else begin
          state_s = IDLE;
          p_cnt_s = P_ZERO;
        end
      end
      PENDING: begin
        if (!mon.enable || !cond_s) begin
          state_s = IDLE;
          p_cnt_s = P_ZERO;
        end else if (p_cnt_r == P_LAST) begin
          state_s = FAULT;
          p_cnt_s = P_ZERO;
        end else begin
          state_s = PENDING;
          p_cnt_s = p_cnt_r + P_ONE;
        end
      end
      FAULT: begin
        // enable is deliberately ignored: disarming must not hide a live fault
        p_cnt_s = P_ZERO;
        if (!cond_s) begin
          state_s = (STICKY != 0) ? LATCHED : IDLE;
        end else begin
          state_s = FAULT;
        end
      end
      LATCHED: begin
        state_s = LATCHED;
        p_cnt_s = P_ZERO;
      end
      default: begin
        state_s = IDLE;
        p_cnt_s = P_ZERO;
      end
    endcase

    error_s       = (state_s == FAULT) || (state_s == LATCHED);
    fault_entry_s = (state_s == FAULT) && (state_r != FAULT);
    if (fault_entry_s && (count_r != CNT_MAX)) begin
      count_s = count_r + CNT_ONE;
    end else begin
      count_s = count_r;
    end
  end

  // Input sampling stage; clear leaves it running.
  always_ff @(posedge clk) begin
    if (rst) begin
      sensors_r <= {NUM_SENSORS{1'b0}};
    end else begin
      sensors_r <= mon.sensors;
    end
  end

  // Monitor state registers with rst > clear > FSM priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      p_cnt_r <= P_ZERO;
      error_r <= 1'b0;
      count_r <= {CNT_WIDTH{1'b0}};
    end else if (mon.clear) begin
      state_r <= IDLE;
      p_cnt_r <= P_ZERO;
      error_r <= 1'b0;
      count_r <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      p_cnt_r <= p_cnt_s;
      error_r <= error_s;
      count_r <= count_s;
    end
  end

  assign mon.error       = error_r;
  assign mon.error_cond  = cond_s;
  assign mon.fault_count = count_r;
  assign mon.busy        = (state_r == PENDING);

endmodule

// File: tb/tb_sensor_monitor.sv
// Directed bench for sensor_monitor: a sticky default instance, a non-sticky
// instance and a 2-bit-counter non-sticky instance share one clock.
module tb_sensor_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  sensor_monitor_if #(.NUM_SENSORS(4), .CNT_WIDTH(8)) m_if ();
  sensor_monitor_if #(.NUM_SENSORS(4), .CNT_WIDTH(8)) ns_if ();
  sensor_monitor_if #(.NUM_SENSORS(4), .CNT_WIDTH(2)) sat_if ();

  sensor_monitor #(.NUM_SENSORS(4), .PERSIST(3), .CNT_WIDTH(8), .STICKY(1))
    dut (.clk(clk), .rst(rst), .mon(m_if));
  sensor_monitor #(.NUM_SENSORS(4), .PERSIST(3), .CNT_WIDTH(8), .STICKY(0))
    dut_ns (.clk(clk), .rst(rst), .mon(ns_if));
  sensor_monitor #(.NUM_SENSORS(4), .PERSIST(3), .CNT_WIDTH(2), .STICKY(0))
    dut_sat (.clk(clk), .rst(rst), .mon(sat_if));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    m_if.sensors = 4'b1111; m_if.enable = 1'b1; m_if.clear = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if ({m_if.error, m_if.busy, m_if.fault_count} !== {1'b0, 1'b0, 8'd0}) begin
        $display("FAIL reset_hold cyc %0d: got err=%b busy=%b cnt=%0d want 0/0/0",
                 i, m_if.error, m_if.busy, m_if.fault_count);
        n_bad++;
      end
    end
    rst = 1'b0;
    // edge 1 samples 1111, error after edge 4
    for (int i = 1; i <= 4; i++) begin
      step();
      n_cmp++;
      if (m_if.error !== (i == 4)) begin
        $display("FAIL reset_release_error edge %0d: got %b want %b", i, m_if.error, (i == 4));
        n_bad++;
      end
      n_cmp++;
      if (m_if.busy !== (i == 2 || i == 3)) begin
        $display("FAIL reset_release_busy edge %0d: got %b want %b", i, m_if.busy, (i == 2 || i == 3));
        n_bad++;
      end
    end
    n_cmp++;
    if (m_if.fault_count !== 8'd1) begin
      $display("FAIL reset_release_count: got %0d want 1", m_if.fault_count);
      n_bad++;
    end
    // rst while in FAULT returns everything to reset values
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_if.sensors = 4'b0000;
    n_cmp++;
    if ({m_if.error, m_if.error_cond, m_if.busy, m_if.fault_count} !== {3'b000, 8'd0}) begin
      $display("FAIL reset_mid_fault: got err=%b cond=%b busy=%b cnt=%0d want 0/0/0/0",
               m_if.error, m_if.error_cond, m_if.busy, m_if.fault_count);
      n_bad++;
    end
    step();
  endtask

  task automatic test_glitch();
    logic [4:0] exp_cond;
    logic [4:0] exp_busy;
    exp_cond = 5'b00011;
    exp_busy = 5'b00110;
    m_if.enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      m_if.sensors = (i < 2) ? 4'b0001 : 4'b0000;
      step();
      n_cmp++;
      if ({m_if.error_cond, m_if.busy, m_if.error} !== {exp_cond[i], exp_busy[i], 1'b0}) begin
        $display("FAIL glitch edge %0d: got cond=%b busy=%b err=%b want %b/%b/0",
                 i + 1, m_if.error_cond, m_if.busy, m_if.error, exp_cond[i], exp_busy[i]);
        n_bad++;
      end
    end
    n_cmp++;
    if (m_if.fault_count !== 8'd0) begin
      $display("FAIL glitch_count: got %0d want 0", m_if.fault_count);
      n_bad++;
    end
  endtask

  task automatic test_rule();
    logic [15:0] truth;
    truth = 16'hEEEA;
    m_if.enable = 1'b1;
    for (int v = 0; v < 16; v++) begin
      m_if.sensors = 4'(v);
      for (int i = 0; i < 4; i++) step();
      n_cmp++;
      if ({m_if.error, m_if.error_cond} !== {truth[v], truth[v]}) begin
        $display("FAIL rule sensors=%b: got err=%b cond=%b want %b", 4'(v),
                 m_if.error, m_if.error_cond, truth[v]);
        n_bad++;
      end
      n_cmp++;
      if (m_if.fault_count !== {7'd0, truth[v]}) begin
        $display("FAIL rule_count sensors=%b: got %0d want %0d", 4'(v), m_if.fault_count, truth[v]);
        n_bad++;
      end
      m_if.sensors = 4'b0000; m_if.clear = 1'b1;
      step();
      m_if.clear = 1'b0;
      step();
    end
  endtask

  task automatic test_sticky();
    m_if.enable = 1'b1;
    m_if.sensors = 4'b1010;
    for (int i = 0; i < 5; i++) step();
    m_if.sensors = 4'b0000;
    m_if.enable = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_cmp++;
    if ({m_if.error, m_if.error_cond, m_if.busy, m_if.fault_count} !== {3'b100, 8'd1}) begin
      $display("FAIL sticky_latched: got err=%b cond=%b busy=%b cnt=%0d want 1/0/0/1",
               m_if.error, m_if.error_cond, m_if.busy, m_if.fault_count);
      n_bad++;
    end
    m_if.clear = 1'b1;
    step();
    m_if.clear = 1'b0;
    n_cmp++;
    if ({m_if.error, m_if.fault_count} !== {1'b0, 8'd0}) begin
      $display("FAIL sticky_clear: got err=%b cnt=%0d want 0/0", m_if.error, m_if.fault_count);
      n_bad++;
    end
    step();
    n_cmp++;
    if (m_if.error !== 1'b0) begin
      $display("FAIL sticky_after_clear: got %b want 0", m_if.error);
      n_bad++;
    end
  endtask

  task automatic test_clear_vs_entry();
    m_if.enable = 1'b1;
    m_if.sensors = 4'b0001;
    for (int i = 0; i < 3; i++) step();
    m_if.clear = 1'b1;
    step();
    m_if.clear = 1'b0;
    n_cmp++;
    if ({m_if.error, m_if.fault_count} !== {1'b0, 8'd0}) begin
      $display("FAIL clear_wins: got err=%b cnt=%0d want 0/0", m_if.error, m_if.fault_count);
      n_bad++;
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      n_cmp++;
      if ({m_if.busy, m_if.error} !== {(i < 3), (i == 3)}) begin
        $display("FAIL redetect edge %0d: got busy=%b err=%b want %b/%b",
                 i, m_if.busy, m_if.error, (i < 3), (i == 3));
        n_bad++;
      end
    end
    n_cmp++;
    if (m_if.fault_count !== 8'd1) begin
      $display("FAIL redetect_count: got %0d want 1", m_if.fault_count);
      n_bad++;
    end
    m_if.sensors = 4'b0000; m_if.clear = 1'b1;
    step();
    m_if.clear = 1'b0;
  endtask

  task automatic test_non_sticky();
    logic [9:0] exp_err;
    exp_err = 10'b10_0001_1000;
    ns_if.enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ns_if.sensors = (i < 4 || i >= 6) ? 4'b0001 : 4'b0000;
      step();
      n_cmp++;
      if (ns_if.error !== exp_err[i]) begin
        $display("FAIL non_sticky edge %0d: got %b want %b", i + 1, ns_if.error, exp_err[i]);
        n_bad++;
      end
    end
    n_cmp++;
    if (ns_if.fault_count !== 8'd2) begin
      $display("FAIL non_sticky_count: got %0d want 2", ns_if.fault_count);
      n_bad++;
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    sat_if.enable = 1'b1;
    for (int f = 1; f <= 5; f++) begin
      sat_if.sensors = 4'b0001;
      for (int i = 0; i < 4; i++) step();
      exp_cnt = (f > 3) ? 2'd3 : 2'(f);
      n_cmp++;
      if ({sat_if.error, sat_if.fault_count} !== {1'b1, exp_cnt}) begin
        $display("FAIL saturation fault %0d: got err=%b cnt=%0d want 1/%0d",
                 f, sat_if.error, sat_if.fault_count, exp_cnt);
        n_bad++;
      end
      sat_if.sensors = 4'b0000;
      step(); step();
    end
    sat_if.enable = 1'b0;
    sat_if.sensors = 4'b0001;
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if ({sat_if.error, sat_if.busy, sat_if.error_cond} !== 3'b001) begin
      $display("FAIL disabled_idle: got err=%b busy=%b cond=%b want 0/0/1",
               sat_if.error, sat_if.busy, sat_if.error_cond);
      n_bad++;
    end
    sat_if.enable = 1'b1;
    for (int i = 0; i < 3; i++) step();
    sat_if.enable = 1'b0;
    step(); step();
    n_cmp++;
    if ({sat_if.error, sat_if.fault_count} !== {1'b1, 2'd3}) begin
      $display("FAIL enable_drop_in_fault: got err=%b cnt=%0d want 1/3",
               sat_if.error, sat_if.fault_count);
      n_bad++;
    end
  endtask

  initial begin
    m_if.sensors = 4'b0000;   m_if.enable = 1'b0;   m_if.clear = 1'b0;
    ns_if.sensors = 4'b0000;  ns_if.enable = 1'b0;  ns_if.clear = 1'b0;
    sat_if.sensors = 4'b0000; sat_if.enable = 1'b0; sat_if.clear = 1'b0;
    test_reset();
    test_glitch();
    test_rule();
    test_sticky();
    test_clear_vs_entry();
    test_non_sticky();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sensor_monitor.md
Name: sensor_monitor

Overview:
Parametrised N-channel sensor fault monitor, the successor to the 4-input combinational sensor error detector. It registers the sensor inputs and evaluates the critical/qualified error rule on the registered values. A persistence filter rejects short glitches, and errors can be latched (sticky) until software clears them. It also keeps a saturating count of fault events for the status block.

Parameters:
NUM_SENSORS  4  number of sensor inputs; legal range 3 or more
PERSIST      3  consecutive cycles the condition must hold before error asserts; legal range 1 or more
CNT_WIDTH    8  width of fault_count
STICKY       1  1 = error latches until clear; 0 = error drops when the condition drops

Ports:
clk          input   1            system clock, rising edge
rst          input   1            synchronous active-high reset
sensors      input   NUM_SENSORS  raw sensor levels
enable       input   1            arms detection of new faults
clear        input   1            synchronous clear of error state and fault_count
error        output  1            filtered/latched error flag, registered
error_cond   output  1            instantaneous rule result on sampled sensors
fault_count  output  CNT_WIDTH    number of FAULT entries, saturating
busy         output  1            high while in PENDING

Behaviour:
- Reset: every register clears on rst=1 at a rising clk edge. After reset:
  - s_q=0, state=IDLE, p_cnt=0
  - error=0, error_cond=0, fault_count=0, busy=0
- Input stage: s_q <= sensors every cycle. There is no further synchronisation.
- Rule: cond = s_q[0] | (s_q[1] & OR(s_q[NUM_SENSORS-1:2])).
  - For NUM_SENSORS=4 this equals the legacy rule s0 | s1&s3 | s1&s2.
  - error_cond = cond, decoded combinationally from s_q.
- Persistence counter p_cnt: width clog2(PERSIST+1).
- Priority at each edge: rst > clear > FSM.
- FSM states: IDLE, PENDING, FAULT, LATCHED.
  - IDLE:
    - enable & cond & PERSIST==1 -> FAULT.
    - enable & cond & PERSIST>1 -> PENDING, p_cnt=1.
    - otherwise stay in IDLE.
  - PENDING:
    - !cond or !enable -> IDLE, p_cnt=0.
    - else if p_cnt==PERSIST-1 -> FAULT, p_cnt=0.
    - else p_cnt++.
  - FAULT:
    - !cond -> LATCHED if STICKY=1, IDLE if STICKY=0.
    - else stay. enable is ignored here; disabling never masks an existing fault.
  - LATCHED: stay until clear. cond and enable are ignored.
- error: registered, equals 1 exactly when the next state is FAULT or LATCHED. It never glitches.
- busy: 1 exactly when state is PENDING.
- Latency: sensors sampled at edge k holding cond for samples k..k+PERSIST-1 -> error high after edge k+PERSIST.
- Glitch rejection: a cond pulse shorter than PERSIST samples produces no error, no count and returns to IDLE.
- fault_count:
  - Increments by 1 on each transition into FAULT, from IDLE or PENDING.
  - Holds at 2^CNT_WIDTH-1 (saturates, no wrap).
  - Remaining in FAULT does not count.
  - Re-entry from IDLE after a STICKY=0 drop counts again.
- clear:
  - Forces state=IDLE, p_cnt=0, error=0, fault_count=0 at the next edge.
  - s_q is unaffected.
  - If cond and enable are still true, the following edge re-enters PENDING (or FAULT if PERSIST=1). The fault is re-detected after PERSIST more edges and counts as a new fault.
- Simultaneous clear with a FAULT entry: clear wins; count=0, error=0.
- rst mid-PENDING/FAULT/LATCHED: returns to reset values at the next edge. No partial count survives.

Test Plan:
- Reset: sensors=4'b1111, enable=1, rst=1 for 2 cycles -> error=0, fault_count=0, busy=0 throughout.
  - Then release rst -> error=1 at 3 edges after the first s_q=1111 sample; fault_count=1.
- Glitch rejection (N=4, P=3): sensors=4'b0001 for 2 cycles, then 0 -> error_cond pulses for 2 cycles, busy=1, error stays 0, fault_count=0, returns to IDLE.
- Rule coverage: sweep all 16 sensors values held for 4 cycles, clear between each.
  - error=1 exactly for 0001/0011/0101/0111/1001/1011/1101/1111/0110/1010/1110.
  - error=0 for 0000/0010/0100/1000/1100.
- Sticky latch: 4'b1010 for 5 cycles, then 0000 -> error stays 1 in LATCHED.
  - Pulse clear -> error=0 next edge, fault_count=0.
- Non-sticky (STICKY=0): 0001 for 4 cycles, 0 for 2, 0001 for 4 cycles -> error drops after cond drops, fault_count=2.
- Saturation/enable (CNT_WIDTH=2, STICKY=0): 5 separate 4-cycle faults -> fault_count=3 and holds.
  - enable=0 with 0001 in IDLE -> no error.
  - enable dropped while in FAULT -> error stays 1.
